// File: rtl/tree_enc_pkg.sv
// Shared constants and helpers for the pipelined minimum-finder tree.
// Optional feature macro: TREE_ENC_BEST2_EN (adds a second-best tuple per node).
package tree_enc_pkg;

    localparam int NCAND_MAX = 32;
    localparam int PRI_W_MAX = 16;
    localparam int IDX_W_MAX = 5;

`ifdef TREE_ENC_BEST2_EN
    localparam int TUPLES_PER_NODE = 2;
`else
    localparam int TUPLES_PER_NODE = 1;
`endif

    // Widest-case node tuple, for consumers holding results outside a
    // parametrised scope. Inside the tree the modules use width-exact copies.
    typedef struct packed {
        logic                 found;
        logic [PRI_W_MAX-1:0] pri;
        logic [IDX_W_MAX-1:0] idx;
    } tuple_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/tree_min_node.sv
// Combinational merge of two child tuples of the minimum tree.
// Ties and equal priorities resolve to the left (lower-index) child; the
// index bit for this level is the side that won.
// Optional feature macro: TREE_ENC_BEST2_EN (also merges second-best tuples).
module tree_min_node
    import tree_enc_pkg::*;
#(
    parameter int PRI_W = 10,
    parameter int IDX_W = 3,
    parameter int LEVEL = 0
) (
    input  logic [TUPLES_PER_NODE*(1+PRI_W+IDX_W)-1:0] l,
    input  logic [TUPLES_PER_NODE*(1+PRI_W+IDX_W)-1:0] r,
    output logic [TUPLES_PER_NODE*(1+PRI_W+IDX_W)-1:0] o
);

    typedef struct packed {
        logic             found;
        logic [PRI_W-1:0] pri;
        logic [IDX_W-1:0] idx;
    } tup_t;

`ifdef TREE_ENC_BEST2_EN
    typedef struct packed { tup_t b; tup_t s; } node_t;
`else
    typedef struct packed { tup_t b; } node_t;
`endif

    node_t ln;
    node_t rn;
    node_t on;
    node_t win;
    logic  take_r;
`ifdef TREE_ENC_BEST2_EN
    node_t los;
    logic  pick_los;
`endif

    assign ln = l;
    assign rn = r;
    assign o  = on;

    // Pick the winning child; unfound results carry all-zero data.
    always_comb begin
        take_r = rn.b.found && (!ln.b.found || (rn.b.pri < ln.b.pri));
        win    = take_r ? rn : ln;
        on     = '0;
        if (win.b.found) begin
            on.b = win.b;
            on.b.idx[LEVEL] = take_r;
        end
`ifdef TREE_ENC_BEST2_EN
        // Second best is the better of the loser's best and the winner's
        // second; on equal priority the left-side tuple has the lower index.
        los      = take_r ? ln : rn;
        pick_los = los.b.found &&
                   (!win.s.found || (los.b.pri < win.s.pri) ||
                    ((los.b.pri == win.s.pri) && take_r));
        if (pick_los) begin
            on.s = los.b;
            on.s.idx[LEVEL] = ~take_r;
        end else if (win.s.found) begin
            on.s = win.s;
            on.s.idx[LEVEL] = take_r;
        end
`endif
    end

endmodule

// File: rtl/tree_encoder_min_pipe.sv
// Fully pipelined minimum-priority finder over NCAND candidates.
// One registered tree level per clock, latency clog2(NCAND), one new
// candidate set accepted every clock, no back-pressure.
// NCAND must be a power of two in 2..NCAND_MAX.
// Optional feature macro: TREE_ENC_BEST2_EN (second-best outputs best2_*).
module tree_encoder_min_pipe
    import tree_enc_pkg::*;
#(
    parameter int NCAND = 8,
    parameter int PRI_W = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_vld,
    input  logic [NCAND-1:0]          cand_vld,
    input  logic [NCAND*PRI_W-1:0]    cand_pri,
    output logic                      best_vld,
    output logic                      best_found,
    output logic [PRI_W-1:0]          best_pri,
    output logic [clog2(NCAND)-1:0]   best_idx
`ifdef TREE_ENC_BEST2_EN
    ,
    output logic                      best2_found,
    output logic [PRI_W-1:0]          best2_pri,
    output logic [clog2(NCAND)-1:0]   best2_idx
`endif
);

    localparam int IDX_W = clog2(NCAND);
    localparam int LAT   = clog2(NCAND);

    typedef struct packed {
        logic             found;
        logic [PRI_W-1:0] pri;
        logic [IDX_W-1:0] idx;
    } tup_t;

`ifdef TREE_ENC_BEST2_EN
    typedef struct packed { tup_t b; tup_t s; } node_t;
`else
    typedef struct packed { tup_t b; } node_t;
`endif

    // Level k occupies nd/nq[NCAND - (NCAND >> k) +: NCAND >> (k+1)];
    // the root is the last entry.
    node_t          leaf [NCAND];
    node_t          nd   [NCAND-1];
    node_t          nq   [NCAND-1];
    node_t          root;
    logic [LAT-1:0] vld_q;

    // Leaves: a slot is found only when the set is live and the candidate valid.
    always_comb begin
        for (int i = 0; i < NCAND; i++) begin
            leaf[i] = '0;
            if (in_vld && cand_vld[i]) begin
                leaf[i].b.found = 1'b1;
                leaf[i].b.pri   = cand_pri[i*PRI_W +: PRI_W];
                leaf[i].b.idx   = IDX_W'(i);
            end
        end
    end

    for (genvar k = 0; k < LAT; k++) begin : g_lvl
        localparam int NN  = NCAND >> (k + 1);
        localparam int OFF = NCAND - (NCAND >> k);
        for (genvar j = 0; j < NN; j++) begin : g_node
            node_t l_in;
            node_t r_in;
            if (k == 0) begin : g_from_leaf
                assign l_in = leaf[2*j];
                assign r_in = leaf[2*j+1];
            end else begin : g_from_level
                localparam int POFF = NCAND - (NCAND >> (k - 1));
                assign l_in = nq[POFF + 2*j];
                assign r_in = nq[POFF + 2*j + 1];
            end
            tree_min_node #(
                .PRI_W (PRI_W),
                .IDX_W (IDX_W),
                .LEVEL (k)
            ) u_node (
                .l (l_in),
                .r (r_in),
                .o (nd[OFF + j])
            );
        end
    end

    // Level registers and the valid shift register; reset drops sets in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < NCAND - 1; i++) nq[i] <= '0;
        end else begin
            vld_q <= LAT'({vld_q, in_vld});
            nq    <= nd;
        end
    end

    assign root       = nq[NCAND-2];
    assign best_vld   = vld_q[LAT-1];
    assign best_found = best_vld & root.b.found;
    assign best_pri   = best_vld ? root.b.pri : '0;
    assign best_idx   = best_vld ? root.b.idx : '0;
`ifdef TREE_ENC_BEST2_EN
    assign best2_found = best_vld & root.s.found;
    assign best2_pri   = best_vld ? root.s.pri : '0;
    assign best2_idx   = best_vld ? root.s.idx : '0;
`endif

endmodule
